// File: rtl/key_conditioner.sv
// Push-button front end: two-flop synchroniser, per-key debounce, press pulses,
// and a snake heading register that rejects 180-degree reversals across move ticks.
module key_conditioner #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic       clk_25MHz,
    input  logic       reset,
    input  logic [3:0] key_n,
    input  logic       move_tick,
    output logic [3:0] key_level,
    output logic [3:0] press_pulse,
    output logic [1:0] pending_dir,
    output logic [1:0] dir,
    output logic       dir_change
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0] level_q;
    logic [3:0] level_d;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_key
            logic             sync1_q, sync1_d;
            logic             sync2_q, sync2_d;
            logic [CNT_W-1:0] cnt_q, cnt_d;
            logic             lvl_q, lvl_d;
            logic             pressed;

            assign pressed = ~sync2_q;

            always_comb begin
                sync1_d = key_n[gi];
                sync2_d = sync1_q;
                lvl_d   = lvl_q;
                cnt_d   = '0;
                // any return to the accepted level restarts the count from zero
                if (pressed != lvl_q) begin
                    if (cnt_q == CNT_LAST) begin
                        lvl_d = pressed;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk_25MHz) begin
                if (reset) begin
                    sync1_q <= 1'b1;
                    sync2_q <= 1'b1;
                    cnt_q   <= '0;
                    lvl_q   <= 1'b0;
                end else begin
                    sync1_q <= sync1_d;
                    sync2_q <= sync2_d;
                    cnt_q   <= cnt_d;
                    lvl_q   <= lvl_d;
                end
            end

            assign level_q[gi] = lvl_q;
            assign level_d[gi] = lvl_d;
        end
    endgenerate

    logic [3:0] press_pulse_q, press_pulse_d;
    logic [1:0] pending_dir_q, pending_dir_d;
    logic [1:0] dir_q, dir_d;
    logic       dir_change_q, dir_change_d;
    logic [1:0] request;
    logic [1:0] ref_dir;

    assign press_pulse_d = level_d & ~level_q;

    always_comb begin
        request = 2'b11;
        if (press_pulse_q[3])      request = 2'b00;
        else if (press_pulse_q[2]) request = 2'b01;
        else if (press_pulse_q[1]) request = 2'b10;

        // judge reversals against the heading that will be in force after this edge
        ref_dir       = move_tick ? pending_dir_q : dir_q;
        pending_dir_d = pending_dir_q;
        if ((press_pulse_q != 4'b0000) && (request != {ref_dir[1], ~ref_dir[0]})) begin
            pending_dir_d = request;
        end

        dir_d        = move_tick ? pending_dir_q : dir_q;
        dir_change_d = move_tick && (pending_dir_q != dir_q);
    end

    always_ff @(posedge clk_25MHz) begin
        if (reset) begin
            press_pulse_q <= 4'b0000;
            pending_dir_q <= 2'b11;
            dir_q         <= 2'b11;
            dir_change_q  <= 1'b0;
        end else begin
            press_pulse_q <= press_pulse_d;
            pending_dir_q <= pending_dir_d;
            dir_q         <= dir_d;
            dir_change_q  <= dir_change_d;
        end
    end

    assign key_level   = level_q;
    assign press_pulse = press_pulse_q;
    assign pending_dir = pending_dir_q;
    assign dir         = dir_q;
    assign dir_change  = dir_change_q;

endmodule

// File: doc/key_conditioner.md
# key_conditioner

Input conditioning stage between the raw board push-buttons and `game_control`. It synchronises and debounces the four active-low `KEY` lines and produces one-cycle press pulses. It also maintains the snake's committed heading with 180° reversal rejection, resolved against the game's move tick, so `game_control` receives clean, single-event direction requests.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 250000: consecutive stable `clk_25MHz` cycles (10 ms) required before a key level change is accepted; legal range ≥ 2.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES+1)`: debounce counter width.

Ports:
- `clk_25MHz`  in  1: sole clock, pixel clock domain.
- `reset`  in  1: synchronous, active-high.
- `key_n`  in  4: raw asynchronous buttons, active-low; bit 3 up, 2 down, 1 left, 0 right.
- `move_tick`  in  1: one-cycle pulse from `game_control` marking a snake step.
- `key_level`  out  4: debounced pressed level, active-high, same bit order.
- `press_pulse`  out  4: one-cycle pulse per debounced press, same bit order; drives `key_up/down/left/right`.
- `pending_dir`  out  2: direction to apply at the next `move_tick`.
- `dir`  out  2: committed heading; encoding 00 up, 01 down, 10 left, 11 right.
- `dir_change`  out  1: one-cycle pulse when `dir` takes a new value.

## Operation
- Synchroniser: each `key_n` bit passes through 2 flops, then is inverted to pressed = 1. Reset loads the flops with "released".
- Debounce, per key, with counter `cnt`:
  - if the synchronised value equals `key_level`: `cnt` ← 0;
  - else if `cnt == DEBOUNCE_CYCLES-1`: `key_level` toggles and `cnt` ← 0;
  - else `cnt` ← `cnt+1`.
- Any bounce back to the current level before the count completes clears `cnt`; no partial credit is kept.
- Press detect: `press_pulse[i]` is registered and high for exactly the cycle in which `key_level[i]` first reads 1. Releases produce no pulse.
- Direction request: in a cycle with any `press_pulse`, choose one key by priority up > down > left > right. Lower-priority simultaneous presses are dropped, not queued.
- Reference heading `ref` = `pending_dir` if `move_tick` is high this cycle, else `dir`.
- A request that is the opposite of `ref` (up↔down, left↔right) is rejected; `pending_dir` is unchanged.
- Otherwise `pending_dir` ← request on the next edge. A later accepted request overwrites an earlier one.
- Commit: on a `move_tick` edge, `dir` ← `pending_dir`. `dir_change` is high the following cycle if the value differed.
- With `move_tick` and an accepted request in the same cycle, `dir` takes the old `pending_dir` and `pending_dir` takes the request. This prevents two legal-looking steps from forming a reversal across one tick.
- Reset: all synchroniser flops released, all `cnt` 0, `key_level` 0000, `press_pulse` 0000, `pending_dir` 11, `dir` 11, `dir_change` 0.
- A key held through reset is re-debounced after reset deasserts and produces a normal `press_pulse`.
- Reset asserted mid-count discards the count.

## Timing
- Let E0 be the first edge sampling a low on `key_n[i]` that then stays stable. `key_level[i]` and `press_pulse[i]` rise after edge E0+1+`DEBOUNCE_CYCLES`.
- `pending_dir` updates 1 edge after `press_pulse`.
- `dir` updates on the `move_tick` edge. `dir_change` is valid in the cycle after that edge and lasts 1 cycle.
- Press-to-`pending_dir` latency: `DEBOUNCE_CYCLES`+3 edges.
- Release latency is symmetric; `key_level` falls after the same count.
- `move_tick` has no handshake. Every pulse commits; `dir_change` stays 0 if `pending_dir` equals `dir`.
- All outputs are registered; there is no combinational path from input to output.

## Test plan
Run with `DEBOUNCE_CYCLES` = 4.
- Clean press, up: hold `key_n[3]`=0 from edge E0. Expect `key_level[3]`=1 and `press_pulse`=1000 for one cycle after edge E0+5, and `pending_dir`=00 after E0+6. Then pulse `move_tick`: expect `dir`=00 and `dir_change` for one cycle.
- Bounce: apply 3-cycle low glitches on `key_n[1]` separated by 1 high cycle, ×5. Expect `key_level`=0000 and no pulse. Then hold low for 6 cycles: expect exactly one `press_pulse`=0010.
- Reversal: after reset (`dir`=11), press left. Expect `pending_dir` to stay 11. Then press up then down before the tick: expect `pending_dir`=01 and, after `move_tick`, `dir`=01.
- Simultaneous presses: debounced presses of up and right rise in the same cycle while `dir`=10. Expect `pending_dir`=00 and right dropped.
- Tick collision: set `dir`=11, `pending_dir`=00, then a down press accepted in the `move_tick` cycle. Expect `dir`=00 and `pending_dir` unchanged at 00 (down rejected against `ref`=00).
- Reset mid-operation: assert `reset` with a key held and a count at 3. Expect all outputs at reset values the next cycle. After release, expect a fresh `press_pulse` 6 edges later.
